alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequenced two-port front end for the shared 16-bit LC-3 ALU (ADD/AND/NOT/PASS selected by a 2-bit ALUK code). It accepts operation requests from two independent requesters, grants the ALU to one at a time with round-robin fairness, and drives the selected operands and ALUK onto the ALU. It registers the ALU result and returns it to the owning requester through a valid/ack response handshake. It sits between the datapath's ALU and the units that share it.

## Interface
- WIDTH, 16, operand/result width
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- Req0_Valid / Req1_Valid  in  1  requester n has an operation pending
- Req0_A / Req1_A  in  WIDTH  operand A
- Req0_B / Req1_B  in  WIDTH  operand B
- Req0_ALUK / Req1_ALUK  in  2  op: 00 A+B, 01 A&B, 10 ~A, 11 A
- Req0_Ready / Req1_Ready  out  1  request accepted this cycle when Valid&Ready
- Resp0_Valid / Resp1_Valid  out  1  result available for requester n
- Resp0_Data / Resp1_Data  out  WIDTH  result, meaningful only while RespN_Valid
- Resp0_Ack / Resp1_Ack  in  1  requester n consumes the result
- ALU_A, ALU_B  out  WIDTH  operands to the ALU
- ALU_K  out  2  ALUK to the ALU
- ALU_Result  in  WIDTH  combinational ALU output

## Operation
- Registers: state {IDLE, EXEC, RESP}, owner (1 bit), prio (1 bit, requester favoured next), op_a, op_b, op_k, result.
- IDLE: if only one Valid, grant it; if both, grant prio. ReqN_Ready = (state==IDLE) & grant==N, combinational, at most one high. On accept: latch A/B/ALUK into op regs, owner<=N, go EXEC. No Valid: stay IDLE.
- EXEC: ALU_A/ALU_B/ALU_K driven from op regs; result<=ALU_Result; go RESP.
- RESP: Resp[owner]_Valid=1, Resp[owner]_Data=result; other port Valid=0. Stay until Resp[owner]_Ack=1, then prio<=~owner, go IDLE.
- ALU_A/B/K always driven from op regs (stable, glitch-free in all states).
- Arithmetic: result is ALU output truncated to WIDTH (ADD wraps mod 2^WIDTH, no carry out).
- Ack on the non-owner port, or Ack while not in RESP: ignored.
- Requester must hold Valid and operands until Ready; dropping Valid before grant withdraws the request with no side effect.
- Resp0_Data/Resp1_Data both drive result register; only the Valid qualifies it.

## Timing
- Reset (any time, asynchronous): state=IDLE, prio=0, owner=0, op_a/op_b/result=0, op_k=00; all Ready and RespN_Valid 0, ALU_A/B=0, ALU_K=00. An in-flight operation is discarded; no response issued.
- Latency: accept in cycle T, EXEC in T+1, RespN_Valid high from T+2 until Ack cycle inclusive.
- Ack in cycle T+2 (same cycle Valid rises) honoured; IDLE in T+3, next accept earliest T+3. Max throughput one op per 3 cycles.
- Valid arriving during EXEC/RESP waits; Ready stays 0 until IDLE.
- Round robin: after serving N, other requester wins the next tie; a lone requester is granted back-to-back regardless of prio.

## Test plan
- Reset then Req0: A=0x1234, B=0x0001, ALUK=00 -> Req0_Ready same cycle, Resp0_Valid two cycles later, Resp0_Data=0x1235, Resp1_Valid stays 0.
- Wrap/ops: A=0xFFFF,B=0x0002,ADD -> 0x0001; A=0xF0F0,B=0x3C3C,AND -> 0x3030; A=0x00FF,NOT -> 0xFF00; A=0xBEEF,PASS -> 0xBEEF.
- Both Valid every cycle, Ack immediate, 4 ops -> grants alternate 0,1,0,1; each result on the matching port only.
- Owner holds off Ack 5 cycles while other requester Valid -> Resp stays Valid with stable data, other Ready stays 0; grant to other the cycle after Ack+1.
- Reset asserted during EXEC -> outputs zero immediately (asynchronous), no RespN_Valid after release, next request served with prio=0.
- Ack on wrong port / Ack in IDLE -> no state change, response still pending on owner port.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared LC-3 ALU.
// Grants one requester at a time, registers the ALU result and returns it through a valid/ack handshake.
module alu_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0_Valid,
  input  logic [WIDTH-1:0] Req0_A,
  input  logic [WIDTH-1:0] Req0_B,
  input  logic [1:0]       Req0_ALUK,
  output logic             Req0_Ready,
  input  logic             Req1_Valid,
  input  logic [WIDTH-1:0] Req1_A,
  input  logic [WIDTH-1:0] Req1_B,
  input  logic [1:0]       Req1_ALUK,
  output logic             Req1_Ready,
  output logic             Resp0_Valid,
  output logic [WIDTH-1:0] Resp0_Data,
  input  logic             Resp0_Ack,
  output logic             Resp1_Valid,
  output logic [WIDTH-1:0] Resp1_Data,
  input  logic             Resp1_Ack,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_K,
  input  logic [WIDTH-1:0] ALU_Result
);

  localparam int unsigned KW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner;
  logic             prio;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [KW-1:0]    op_k;
  logic [WIDTH-1:0] result;
  logic [1:0]       resp_valid;

  logic             grant_c;
  logic             any_valid_c;
  logic             owner_ack_c;

  // Tie goes to prio; a lone requester always wins.
  always_comb begin
    grant_c     = 1'b0;
    any_valid_c = Req0_Valid | Req1_Valid;
    if (Req0_Valid && Req1_Valid) begin
      grant_c = prio;
    end else if (Req1_Valid) begin
      grant_c = 1'b1;
    end
  end

  always_comb begin
    Req0_Ready = 1'b0;
    Req1_Ready = 1'b0;
    if (state == IDLE) begin
      Req0_Ready = Req0_Valid & ~grant_c;
      Req1_Ready = Req1_Valid &  grant_c;
    end
  end

  assign owner_ack_c = owner ? Resp1_Ack : Resp0_Ack;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      prio       <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_k       <= '0;
      result     <= '0;
      resp_valid <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid_c) begin
            owner <= grant_c;
            op_a  <= grant_c ? Req1_A    : Req0_A;
            op_b  <= grant_c ? Req1_B    : Req0_B;
            op_k  <= grant_c ? Req1_ALUK : Req0_ALUK;
            state <= EXEC;
          end
        end
        EXEC: begin
          result     <= WIDTH'(ALU_Result);
          resp_valid <= owner ? 2'b10 : 2'b01;
          state      <= RESP;
        end
        RESP: begin
          // Only the owner's ack releases the response; the other port is ignored.
          if (owner_ack_c) begin
            resp_valid <= 2'b00;
            prio       <= ~owner;
            state      <= IDLE;
          end
        end
        default: begin
          resp_valid <= 2'b00;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign ALU_A       = op_a;
  assign ALU_B       = op_b;
  assign ALU_K       = op_k;
  assign Resp0_Valid = resp_valid[0];
  assign Resp1_Valid = resp_valid[1];
  assign Resp0_Data  = result;
  assign Resp1_Data  = result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; the bench models the shared ALU itself.
module tb_alu_arbiter;

  localparam int unsigned WIDTH = 16;

  logic             Clk;
  logic             Reset;
  logic             Req0_Valid, Req1_Valid;
  logic [WIDTH-1:0] Req0_A, Req0_B, Req1_A, Req1_B;
  logic [1:0]       Req0_ALUK, Req1_ALUK;
  logic             Req0_Ready, Req1_Ready;
  logic             Resp0_Valid, Resp1_Valid;
  logic [WIDTH-1:0] Resp0_Data, Resp1_Data;
  logic             Resp0_Ack, Resp1_Ack;
  logic [WIDTH-1:0] ALU_A, ALU_B, ALU_Result;
  logic [1:0]       ALU_K;

  int total  = 0;
  int passed = 0;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req0_Valid (Req0_Valid),
    .Req0_A     (Req0_A),
    .Req0_B     (Req0_B),
    .Req0_ALUK  (Req0_ALUK),
    .Req0_Ready (Req0_Ready),
    .Req1_Valid (Req1_Valid),
    .Req1_A     (Req1_A),
    .Req1_B     (Req1_B),
    .Req1_ALUK  (Req1_ALUK),
    .Req1_Ready (Req1_Ready),
    .Resp0_Valid(Resp0_Valid),
    .Resp0_Data (Resp0_Data),
    .Resp0_Ack  (Resp0_Ack),
    .Resp1_Valid(Resp1_Valid),
    .Resp1_Data (Resp1_Data),
    .Resp1_Ack  (Resp1_Ack),
    .ALU_A      (ALU_A),
    .ALU_B      (ALU_B),
    .ALU_K      (ALU_K),
    .ALU_Result (ALU_Result)
  );

  // Shared LC-3 ALU
  always_comb begin
    case (ALU_K)
      2'b00:   ALU_Result = ALU_A + ALU_B;
      2'b01:   ALU_Result = ALU_A & ALU_B;
      2'b10:   ALU_Result = ~ALU_A;
      default: ALU_Result = ALU_A;
    endcase
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic [15:0] a, input logic [15:0] b, input logic [1:0] k);
    if (p) begin
      Req1_Valid = 1'b1; Req1_A = a; Req1_B = b; Req1_ALUK = k;
    end else begin
      Req0_Valid = 1'b1; Req0_A = a; Req0_B = b; Req0_ALUK = k;
    end
  endtask

  // Lone request on port p, checked through accept, exec, response and ack.
  task automatic run_op(input bit p, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] k, input logic [15:0] exp, input string tag);
    drive(p, a, b, k);
    #1;
    check({tag, "_ready"}, p ? Req1_Ready : Req0_Ready, 1);
    check({tag, "_other_ready"}, p ? Req0_Ready : Req1_Ready, 0);
    step();
    Req0_Valid = 1'b0; Req1_Valid = 1'b0;
    #1;
    check({tag, "_exec_valid"}, {Resp1_Valid, Resp0_Valid}, 0);
    check({tag, "_alu_a"}, ALU_A, a);
    step();
    check({tag, "_resp_valid"}, p ? Resp1_Valid : Resp0_Valid, 1);
    check({tag, "_other_valid"}, p ? Resp0_Valid : Resp1_Valid, 0);
    check({tag, "_data"}, p ? Resp1_Data : Resp0_Data, exp);
    if (p) Resp1_Ack = 1'b1; else Resp0_Ack = 1'b1;
    step();
    Resp0_Ack = 1'b0; Resp1_Ack = 1'b0;
    #1;
    check({tag, "_released"}, {Resp1_Valid, Resp0_Valid}, 0);
  endtask

  initial begin
    logic [15:0] exp0, exp1;
    bit          g;
    Reset = 1'b1;
    Req0_Valid = 0; Req0_A = 0; Req0_B = 0; Req0_ALUK = 0;
    Req1_Valid = 0; Req1_A = 0; Req1_B = 0; Req1_ALUK = 0;
    Resp0_Ack = 0; Resp1_Ack = 0;
    step();
    step();
    Reset = 1'b0;
    #1;
    check("rst_ready", {Req1_Ready, Req0_Ready}, 0);
    check("rst_resp_valid", {Resp1_Valid, Resp0_Valid}, 0);
    check("rst_alu", {ALU_K, ALU_A, ALU_B}, 0);
    step();

    // Basic op and the four ALU functions
    run_op(0, 16'h1234, 16'h0001, 2'b00, 16'h1235, "add0");
    run_op(0, 16'hFFFF, 16'h0002, 2'b00, 16'h0001, "wrap");
    run_op(1, 16'hF0F0, 16'h3C3C, 2'b01, 16'h3030, "and1");
    run_op(0, 16'h00FF, 16'h0000, 2'b10, 16'hFF00, "not0");
    run_op(1, 16'hBEEF, 16'h0000, 2'b11, 16'hBEEF, "pass1");

    // Contention from prio=0: grants must alternate 0,1,0,1
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      g = i[0];
      Req0_Valid = 1; Req0_A = 16'h0010 + 16'(i); Req0_B = 16'h0001; Req0_ALUK = 2'b00;
      Req1_Valid = 1; Req1_A = 16'h0100 + 16'(i); Req1_B = 16'h0002; Req1_ALUK = 2'b00;
      exp0 = 16'h0011 + 16'(i);
      exp1 = 16'h0102 + 16'(i);
      #1;
      check($sformatf("rr%0d_ready", i), {Req1_Ready, Req0_Ready}, g ? 2'b10 : 2'b01);
      step();
      check($sformatf("rr%0d_exec_ready", i), {Req1_Ready, Req0_Ready}, 0);
      step();
      check($sformatf("rr%0d_valid", i), {Resp1_Valid, Resp0_Valid}, g ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_data", i), g ? Resp1_Data : Resp0_Data, g ? exp1 : exp0);
      if (g) Resp1_Ack = 1; else Resp0_Ack = 1;
      step();
      Resp0_Ack = 0; Resp1_Ack = 0;
    end
    Req0_Valid = 0; Req1_Valid = 0;

    // Owner holds off ack while the other requester waits; wrong-port ack ignored
    drive(0, 16'h0003, 16'h0004, 2'b00);
    drive(1, 16'h1111, 16'h3333, 2'b01);
    #1;
    check("hold_grant", {Req1_Ready, Req0_Ready}, 2'b01);
    step();
    Req0_Valid = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_valid", i), {Resp1_Valid, Resp0_Valid}, 2'b01);
      check($sformatf("hold%0d_data", i), Resp0_Data, 16'h0007);
      check($sformatf("hold%0d_r1", i), Req1_Ready, 0);
      Resp1_Ack = (i == 2);
      step();
    end
    Resp1_Ack = 0;
    check("wrong_ack_pending", {Resp1_Valid, Resp0_Valid}, 2'b01);
    Resp0_Ack = 1;
    step();
    Resp0_Ack = 0;
    #1;
    check("hold_handover", {Req1_Ready, Req0_Ready}, 2'b10);
    check("hold_released", Resp0_Valid, 0);
    step();
    Req1_Valid = 0;
    step();
    check("hold_r1_valid", {Resp1_Valid, Resp0_Valid}, 2'b10);
    check("hold_r1_data", Resp1_Data, 16'h1111);
    Resp1_Ack = 1;
    step();
    Resp1_Ack = 0;

    // Ack while idle does nothing
    Resp0_Ack = 1; Resp1_Ack = 1;
    step();
    Resp0_Ack = 0; Resp1_Ack = 0;
    #1;
    check("idle_ack_valid", {Resp1_Valid, Resp0_Valid}, 0);
    run_op(0, 16'h7FFF, 16'h0001, 2'b00, 16'h8000, "after_idle_ack");

    // Reset during EXEC with prio=1 beforehand
    drive(0, 16'h5555, 16'h0001, 2'b01);
    #1;
    check("rx_ready", Req0_Ready, 1);
    step();
    Req0_Valid = 0;
    #1;
    check("rx_exec_alu", {ALU_K, ALU_A}, {2'b01, 16'h5555});
    Reset = 1'b1;
    #1;
    check("rx_async_alu", {ALU_K, ALU_A, ALU_B}, 0);
    check("rx_async_valid", {Resp1_Valid, Resp0_Valid}, 0);
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rx_no_resp%0d", i), {Resp1_Valid, Resp0_Valid}, 0);
      step();
    end
    drive(0, 16'h0020, 16'h0002, 2'b00);
    drive(1, 16'h0040, 16'h0004, 2'b00);
    #1;
    check("rx_prio0", {Req1_Ready, Req0_Ready}, 2'b01);
    step();
    Req0_Valid = 0; Req1_Valid = 0;
    step();
    check("rx_data", {Resp1_Valid, Resp0_Valid, Resp0_Data}, {2'b01, 16'h0022});
    Resp0_Ack = 1;
    step();
    Resp0_Ack = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
